sc_hdlc_rx_arbiter: RTL and testbench

// Packet-level arbiter merging the RX streams of NUM_CH sc_hdlc_warpper channels into one AXIS stream toward host DMA.

---
 rtl/sc_hdlc_pkg.sv | 34 +++
 rtl/sc_hdlc_axis_skid.sv | 61 ++++++
 rtl/sc_hdlc_rx_arbiter.sv | 145 ++++++++++++++
 tb/tb_sc_hdlc_rx_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_hdlc_pkg.sv
// Shared definitions for the HDLC RX merge path: AXIS beat layout, arbiter FSM encoding
// and a priority-encoder helper.
package sc_hdlc_pkg;

   localparam int DATA_W = 8;
   localparam int ID_W   = 5;
   localparam int DEST_W = 5;
   localparam int USER_W = 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic              tlast;
      logic              tkeep;
      logic [ID_W-1:0]   tid;
      logic [DEST_W-1:0] tdest;
      logic [USER_W-1:0] tuser;
   } axis_beat_t;

   // Index of the lowest set bit; 0 when the vector is empty (callers gate on |vec).
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sc_hdlc_axis_skid.sv
// Two-entry AXIS register slice. Upstream ready depends only on occupancy, so the
// downstream ready never reaches the upstream side combinationally.
module sc_hdlc_axis_skid
   import sc_hdlc_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       s_valid_i,
   output logic       s_ready_o,
   input  axis_beat_t s_beat_i,
   output logic       m_valid_o,
   input  logic       m_ready_i,
   output axis_beat_t m_beat_o
);

   logic [1:0] count_q, count_d;
   axis_beat_t head_q, head_d;
   axis_beat_t tail_q, tail_d;
   logic       push;
   logic       pop;

   assign s_ready_o = (count_q != 2'd2);
   assign m_valid_o = (count_q != 2'd0);
   assign m_beat_o  = head_q;
   assign push      = s_valid_i & s_ready_o;
   assign pop       = m_valid_o & m_ready_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = s_beat_i;
            else                 tail_d = s_beat_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // Simultaneous push/pop only happens with one entry held: the new beat replaces the head.
         2'b11:   head_d = s_beat_i;
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rstn) count_q <= 2'd0;
      else       count_q <= count_d;
   end

   // NOTE: payload storage is deliberately not reset; the occupancy count alone marks it valid.
   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

endmodule

// File: rtl/sc_hdlc_rx_arbiter.sv
// Packet-level arbiter merging NUM_CH HDLC RX streams into one AXIS stream; priority
// (skip_arb) requests beat round-robin, and a grant is held from first beat to tlast.
module sc_hdlc_rx_arbiter
   import sc_hdlc_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter bit OVERRIDE_TID = 1'b1,
   localparam int CH_W        = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]        s_axis_tvalid,
   output logic [NUM_CH-1:0]        s_axis_tready,
   input  logic [NUM_CH-1:0]        s_axis_tlast,
   input  logic [NUM_CH-1:0]        s_axis_tkeep,
   input  logic [NUM_CH*ID_W-1:0]   s_axis_tid,
   input  logic [NUM_CH*DEST_W-1:0] s_axis_tdest,
   input  logic [NUM_CH-1:0]        s_axis_tuser,
   input  logic [NUM_CH-1:0]        pkt_valid,
   input  logic [NUM_CH-1:0]        skip_arb,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     m_axis_tkeep,
   output logic [ID_W-1:0]          m_axis_tid,
   output logic [DEST_W-1:0]        m_axis_tdest,
   output logic [USER_W-1:0]        m_axis_tuser,
   output logic [CH_W-1:0]          cur_ch,
   output logic                     busy,
   output logic [31:0]              pkt_count
);

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]       pkt_count_q, pkt_count_d;

   axis_beat_t        ch_beat [NUM_CH];
   axis_beat_t        sel_beat;
   axis_beat_t        out_beat;
   logic              sel_valid;
   logic              skid_s_ready;
   logic              skid_m_valid;
   logic              m_fire;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] prio_req;
   logic [NUM_CH-1:0] rr_mask;
   logic [NUM_CH-1:0] rr_req;
   logic [CH_W-1:0]   grant_idx;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_beat[i].tdata = s_axis_tdata[DATA_W*i +: DATA_W];
         ch_beat[i].tlast = s_axis_tlast[i];
         ch_beat[i].tkeep = s_axis_tkeep[i];
         ch_beat[i].tid   = s_axis_tid[ID_W*i +: ID_W];
         ch_beat[i].tdest = s_axis_tdest[DEST_W*i +: DEST_W];
         ch_beat[i].tuser = s_axis_tuser[i +: USER_W];
      end
   end

   // Round-robin: lowest eligible index at/after rr_ptr, wrapping to the lowest overall.
   always_comb begin
      elig     = s_axis_tvalid & pkt_valid;
      prio_req = elig & skip_arb;
      for (int i = 0; i < NUM_CH; i++) begin
         rr_mask[i] = (CH_W'(i) >= rr_ptr_q);
      end
      rr_req = elig & rr_mask;
      if (|prio_req)    grant_idx = CH_W'(lowest_set(32'(prio_req)));
      else if (|rr_req) grant_idx = CH_W'(lowest_set(32'(rr_req)));
      else              grant_idx = CH_W'(lowest_set(32'(elig)));
   end

   always_comb begin
      state_d       = state_q;
      cur_ch_d      = cur_ch_q;
      rr_ptr_d      = rr_ptr_q;
      s_axis_tready = '0;
      sel_valid     = 1'b0;
      sel_beat      = ch_beat[cur_ch_q];
      if (OVERRIDE_TID) sel_beat.tid = ID_W'(cur_ch_q);

      unique case (state_q)
         ST_IDLE: begin
            if (|elig) begin
               cur_ch_d = grant_idx;
               state_d  = ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_axis_tready[cur_ch_q] = skid_s_ready;
            sel_valid               = s_axis_tvalid[cur_ch_q];
            if (sel_valid && skid_s_ready && sel_beat.tlast) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sc_hdlc_axis_skid u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid_i (sel_valid),
      .s_ready_o (skid_s_ready),
      .s_beat_i  (sel_beat),
      .m_valid_o (skid_m_valid),
      .m_ready_i (m_axis_tready),
      .m_beat_o  (out_beat)
   );

   assign m_fire      = skid_m_valid & m_axis_tready & out_beat.tlast;
   assign pkt_count_d = pkt_count_q + 32'(m_fire);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cur_ch_q    <= '0;
         rr_ptr_q    <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         rr_ptr_q    <= rr_ptr_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign m_axis_tvalid = skid_m_valid;
   assign m_axis_tdata  = out_beat.tdata;
   assign m_axis_tlast  = out_beat.tlast;
   assign m_axis_tkeep  = out_beat.tkeep;
   assign m_axis_tid    = out_beat.tid;
   assign m_axis_tdest  = out_beat.tdest;
   assign m_axis_tuser  = out_beat.tuser;
   assign cur_ch        = cur_ch_q;
   assign busy          = (state_q == ST_STREAM) | skid_m_valid;
   assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_sc_hdlc_rx_arbiter.sv
// Directed bench for sc_hdlc_rx_arbiter: per-channel packet sources, an output monitor,
// and one task per scenario comparing the merged stream against hand-ordered expectations.
module tb_sc_hdlc_rx_arbiter;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   logic                  clk;
   logic                  rstn;
   logic [NUM_CH*8-1:0]   s_axis_tdata;
   logic [NUM_CH-1:0]     s_axis_tvalid;
   logic [NUM_CH-1:0]     s_axis_tready;
   logic [NUM_CH-1:0]     s_axis_tlast;
   logic [NUM_CH-1:0]     s_axis_tkeep;
   logic [NUM_CH*5-1:0]   s_axis_tid;
   logic [NUM_CH*5-1:0]   s_axis_tdest;
   logic [NUM_CH-1:0]     s_axis_tuser;
   logic [NUM_CH-1:0]     pkt_valid;
   logic [NUM_CH-1:0]     skip_arb;
   logic [7:0]            m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;
   logic                  m_axis_tkeep;
   logic [4:0]            m_axis_tid;
   logic [4:0]            m_axis_tdest;
   logic [0:0]            m_axis_tuser;
   logic [CH_W-1:0]       cur_ch;
   logic                  busy;
   logic [31:0]           pkt_count;

   sc_hdlc_rx_arbiter #(.NUM_CH(NUM_CH), .OVERRIDE_TID(1'b1)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tid    (s_axis_tid),
      .s_axis_tdest  (s_axis_tdest),
      .s_axis_tuser  (s_axis_tuser),
      .pkt_valid     (pkt_valid),
      .skip_arb      (skip_arb),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tuser  (m_axis_tuser),
      .cur_ch        (cur_ch),
      .busy          (busy),
      .pkt_count     (pkt_count)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } src_beat_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [4:0] tid;
      logic [4:0] tdest;
      logic       tuser;
      int         cyc;
   } out_beat_t;

   src_beat_t src_q [NUM_CH][$];
   out_beat_t out_q [$];
   out_beat_t exp_q [$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   onehot_viol = 0;
   int   stall_viol = 0;
   int   pkt_total = 0;
   logic bp_mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NUM_CH; i++) begin
         s_axis_tvalid[i] = (src_q[i].size() != 0);
         if (src_q[i].size() != 0) begin
            s_axis_tdata[8*i +: 8] = src_q[i][0].data;
            s_axis_tlast[i]        = src_q[i][0].last;
         end else begin
            s_axis_tdata[8*i +: 8] = 8'h00;
            s_axis_tlast[i]        = 1'b0;
         end
      end
   endtask

   // Sources pop a beat after each handshake; the monitor records output handshakes and
   // counts one-hot-ready and stall-stability violations for the tests to inspect.
   task automatic run_engine();
      logic [NUM_CH-1:0] fire;
      logic              stall_prev;
      logic [20:0]       held;
      logic [20:0]       now_payload;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         fire = s_axis_tvalid & s_axis_tready & {NUM_CH{rstn}};
         if ($countones(s_axis_tready) > 1) onehot_viol++;
         now_payload = {m_axis_tdata, m_axis_tlast, m_axis_tkeep, m_axis_tid, m_axis_tdest, m_axis_tuser};
         if (rstn) begin
            if (stall_prev && (!m_axis_tvalid || now_payload !== held)) stall_viol++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held       = now_payload;
            if (m_axis_tvalid && m_axis_tready)
               out_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser[0], cyc});
         end else begin
            stall_prev = 1'b0;
         end
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_CH; i++) begin
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         end
         drive_sources();
         m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   function automatic logic [7:0] beat_data(int ch, int pkt, int b);
      return 8'(ch * 64 + pkt * 8 + b);
   endfunction

   task automatic push_pkt(int ch, int pkt, int len);
      for (int b = 0; b < len; b++) src_q[ch].push_back('{beat_data(ch, pkt, b), (b == len - 1)});
   endtask

   // Expected output beat: tid replaced by the channel index, tdest/tuser are per-channel constants.
   task automatic add_exp(int ch, int pkt, int len);
      for (int b = 0; b < len; b++)
         exp_q.push_back('{beat_data(ch, pkt, b), (b == len - 1), 5'(ch), 5'(ch + 3), 1'(ch % 2), 0});
   endtask

   function automatic logic [19:0] key(out_beat_t b);
      return {b.data, b.last, b.tid, b.tdest, b.tuser};
   endfunction

   function automatic string fmt(out_beat_t b);
      return $sformatf("d=%h l=%b id=%0d dst=%0d u=%b", b.data, b.last, b.tid, b.tdest, b.tuser);
   endfunction

   task automatic wait_out(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (out_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      ok = (out_q.size() >= n);
      tick();
      tick();
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
      out_q.delete();
      exp_q.delete();
      pkt_valid = '0;
      skip_arb  = '0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NUM_CH; i++) push_pkt(i, 0, 3);
      pkt_valid = '1;
      skip_arb  = '1;
      tick();
      tick();
      checks++;
      if (s_axis_tready !== '0) begin
         errors++;
         $display("FAIL reset_tready: got %b want 0000", s_axis_tready);
      end
      checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid_busy: got tvalid=%b busy=%b want 0 0", m_axis_tvalid, busy);
      end
      checks++;
      if (pkt_count !== 32'd0 || cur_ch !== 2'd0) begin
         errors++;
         $display("FAIL reset_count_ch: got pkt_count=%0d cur_ch=%0d want 0 0", pkt_count, cur_ch);
      end
      clear_all();
      rstn = 1'b1;
      tick();
      tick();
      checks++;
      if (out_q.size() != 0) begin
         errors++;
         $display("FAIL reset_no_output: got %0d beats want 0", out_q.size());
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      clear_all();
      for (int i = 0; i < NUM_CH; i++) begin
         push_pkt(i, 1, 3);
         add_exp(i, 1, 3);
      end
      pkt_valid = '1;
      wait_out(12, 80, ok);
      checks++;
      if (!ok || out_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rr_count: got %0d beats want %0d", out_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         if (k < out_q.size()) begin
            checks++;
            if (key(out_q[k]) !== key(exp_q[k])) begin
               errors++;
               $display("FAIL rr_beat%0d: got %s want %s", k, fmt(out_q[k]), fmt(exp_q[k]));
            end
         end
      end
      if (out_q.size() >= 12) begin
         checks++;
         if (out_q[11].cyc - out_q[0].cyc != 14) begin
            errors++;
            $display("FAIL rr_timing: got span %0d clks want 14", out_q[11].cyc - out_q[0].cyc);
         end
      end
      pkt_total += 4;
      checks++;
      if (pkt_count !== 32'(pkt_total) || busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_pkt_count: got %0d busy=%b want %0d busy=0", pkt_count, busy, pkt_total);
      end
   endtask

   task automatic test_priority();
      bit ok;
      clear_all();
      for (int i = 0; i < 3; i++) push_pkt(i, 2, 2);
      add_exp(2, 2, 2);
      add_exp(0, 2, 2);
      add_exp(1, 2, 2);
      pkt_valid = 4'b0111;
      skip_arb  = 4'b0100;
      wait_out(6, 60, ok);
      checks++;
      if (!ok || out_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL prio_count: got %0d beats want %0d", out_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         if (k < out_q.size()) begin
            checks++;
            if (key(out_q[k]) !== key(exp_q[k])) begin
               errors++;
               $display("FAIL prio_beat%0d: got %s want %s", k, fmt(out_q[k]), fmt(exp_q[k]));
            end
         end
      end
      // Several priority requests, one of them on a channel without a complete packet.
      clear_all();
      tick();
      for (int i = 0; i < NUM_CH; i++) push_pkt(i, 3, 2);
      add_exp(1, 3, 2);
      add_exp(3, 3, 2);
      add_exp(0, 3, 2);
      pkt_valid = 4'b1011;
      skip_arb  = 4'b1110;
      wait_out(6, 60, ok);
      for (int k = 0; k < 8; k++) tick();
      checks++;
      if (!ok || out_q.size() != exp_q.size() || src_q[2].size() != 2) begin
         errors++;
         $display("FAIL prio_multi_count: got %0d beats ch2_left=%0d want %0d beats ch2_left=2",
                  out_q.size(), src_q[2].size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         if (k < out_q.size()) begin
            checks++;
            if (key(out_q[k]) !== key(exp_q[k])) begin
               errors++;
               $display("FAIL prio_multi_beat%0d: got %s want %s", k, fmt(out_q[k]), fmt(exp_q[k]));
            end
         end
      end
      pkt_total += 6;
      checks++;
      if (pkt_count !== 32'(pkt_total)) begin
         errors++;
         $display("FAIL prio_pkt_count: got %0d want %0d", pkt_count, pkt_total);
      end
      clear_all();
      tick();
   endtask

   task automatic test_no_pkt_valid();
      bit ok;
      clear_all();
      push_pkt(1, 4, 2);
      add_exp(1, 4, 2);
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++;
         if (s_axis_tready !== '0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL nopv_idle%0d: got tready=%b busy=%b tvalid=%b want 0000 0 0",
                     k, s_axis_tready, busy, m_axis_tvalid);
         end
      end
      pkt_valid = 4'b0010;
      tick();
      checks++;
      if (s_axis_tready !== 4'b0010 || cur_ch !== 2'd1) begin
         errors++;
         $display("FAIL nopv_grant: got tready=%b cur_ch=%0d want 0010 1", s_axis_tready, cur_ch);
      end
      wait_out(2, 30, ok);
      checks++;
      if (!ok || out_q.size() != 2 || key(out_q[0]) !== key(exp_q[0]) || key(out_q[1]) !== key(exp_q[1])) begin
         errors++;
         $display("FAIL nopv_data: got %0d beats want 2 matching ch1 packet", out_q.size());
      end
      pkt_total += 1;
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_all();
      push_pkt(0, 5, 4);
      push_pkt(1, 5, 2);
      push_pkt(2, 5, 5);
      push_pkt(3, 5, 1);
      add_exp(2, 5, 5);
      add_exp(3, 5, 1);
      add_exp(0, 5, 4);
      add_exp(1, 5, 2);
      stall_viol = 0;
      bp_mode    = 1'b1;
      pkt_valid  = '1;
      wait_out(12, 400, ok);
      bp_mode = 1'b0;
      tick();
      tick();
      checks++;
      if (!ok || out_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL bp_count: got %0d beats want %0d", out_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
         if (k < out_q.size()) begin
            checks++;
            if (key(out_q[k]) !== key(exp_q[k])) begin
               errors++;
               $display("FAIL bp_beat%0d: got %s want %s", k, fmt(out_q[k]), fmt(exp_q[k]));
            end
         end
      end
      checks++;
      if (stall_viol != 0 || onehot_viol != 0) begin
         errors++;
         $display("FAIL bp_protocol: got stall_viol=%0d onehot_viol=%0d want 0 0", stall_viol, onehot_viol);
      end
      pkt_total += 4;
      checks++;
      if (pkt_count !== 32'(pkt_total)) begin
         errors++;
         $display("FAIL bp_pkt_count: got %0d want %0d", pkt_count, pkt_total);
      end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      int k;
      bit saw_last;
      clear_all();
      push_pkt(2, 6, 5);
      pkt_valid = 4'b0100;
      k = 0;
      while (src_q[2].size() != 3 && k < 30) begin
         tick();
         k++;
      end
      checks++;
      if (src_q[2].size() != 3) begin
         errors++;
         $display("FAIL rstmid_reach_beat2: got %0d beats left want 3", src_q[2].size());
      end
      rstn = 1'b0;
      tick();
      checks++;
      if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_cleared: got tready=%b tvalid=%b busy=%b want 0000 0 0",
                  s_axis_tready, m_axis_tvalid, busy);
      end
      checks++;
      if (pkt_count !== 32'd0 || cur_ch !== 2'd0) begin
         errors++;
         $display("FAIL rstmid_count_ch: got pkt_count=%0d cur_ch=%0d want 0 0", pkt_count, cur_ch);
      end
      saw_last = 1'b0;
      foreach (out_q[j]) if (out_q[j].last) saw_last = 1'b1;
      checks++;
      if (saw_last || out_q.size() > 2) begin
         errors++;
         $display("FAIL rstmid_truncated: got %0d beats tlast_seen=%b want <=2 beats tlast_seen=0",
                  out_q.size(), saw_last);
      end
      clear_all();
      rstn      = 1'b1;
      pkt_total = 0;
      tick();
      // rr_ptr back at 0 gives ch1 before ch3; a stale pointer of 2 would reverse them.
      push_pkt(1, 7, 1);
      push_pkt(3, 7, 1);
      add_exp(1, 7, 1);
      add_exp(3, 7, 1);
      pkt_valid = 4'b1010;
      wait_out(2, 40, ok);
      checks++;
      if (!ok || out_q.size() != 2) begin
         errors++;
         $display("FAIL rstmid_after_count: got %0d beats want 2", out_q.size());
      end
      foreach (exp_q[j]) begin
         if (j < out_q.size()) begin
            checks++;
            if (key(out_q[j]) !== key(exp_q[j])) begin
               errors++;
               $display("FAIL rstmid_after_beat%0d: got %s want %s", j, fmt(out_q[j]), fmt(exp_q[j]));
            end
         end
      end
      checks++;
      if (pkt_count !== 32'd2) begin
         errors++;
         $display("FAIL rstmid_pkt_count: got %0d want 2", pkt_count);
      end
   endtask

   initial begin
      rstn          = 1'b0;
      bp_mode       = 1'b0;
      pkt_valid     = '0;
      skip_arb      = '0;
      m_axis_tready = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         s_axis_tkeep[i]       = 1'b1;
         s_axis_tid[5*i +: 5]   = 5'(20 + i);
         s_axis_tdest[5*i +: 5] = 5'(i + 3);
         s_axis_tuser[i]       = 1'(i % 2);
      end
      fork
         run_engine();
      join_none
      test_reset();
      test_round_robin();
      test_priority();
      test_no_pkt_valid();
      test_backpressure();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
